em_video_timing_gen: RTL and testbench

Pixel timing and test-pattern generator that consumes the 10-bit control word driven by the Avalon PIO (`out_port`) and produces 640x480@60 VGA sync, data-enable and 12-bit RGB. It sits directly downstream of the control PIO and upstream of the board DAC pins. It runs on the system clock, advancing one pixel per `pix_ce` strobe. The control word is shadowed at frame boundaries so that software writes never tear a frame.

---
 rtl/em_video_pkg.sv | 34 +++
 rtl/em_video_pattern.sv | 52 +++++
 rtl/em_video_timing_gen.sv | 121 ++++++++++++
 tb/tb_em_video_timing_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/em_video_pkg.sv
// Shared constants for the VGA timing / test-pattern generator: default 640x480@60
// timing, control-word field positions and pattern encodings.
package em_video_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int CTRL_W       = 10;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_PAT_LSB = 1;
    localparam int CTRL_PAT_MSB = 2;
    localparam int CTRL_COL_LSB = 3;
    localparam int CTRL_COL_MSB = 8;
    localparam int CTRL_INV     = 9;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'b00,
        PAT_VBAR  = 2'b01,
        PAT_HBAR  = 2'b10,
        PAT_CHECK = 2'b11
    } pattern_e;

    // 2-bit colour component to 4-bit DAC code by replication (11 -> F, 10 -> A).
    function automatic logic [3:0] expand_2to4(input logic [1:0] c);
        return {c, c};
    endfunction

endpackage

// File: rtl/em_video_pattern.sv
// Combinational pattern generator: colour for the pixel at (h_cnt, v_cnt) under the
// applied control word, with invert and enable folded in; blanking is left to the caller.
module em_video_pattern
    import em_video_pkg::*;
(
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic [9:0]  ctrl_active,
    output logic [11:0] colour
);

    pattern_e    pat;
    logic [2:0]  h_idx;
    logic [2:0]  v_idx;
    logic        checker_on;
    logic [11:0] raw_colour;
    logic        unused_cnt_bits;

    assign pat        = pattern_e'(ctrl_active[CTRL_PAT_MSB:CTRL_PAT_LSB]);
    assign h_idx      = h_cnt[8:6];
    assign v_idx      = v_cnt[8:6];
    assign checker_on = h_cnt[5] ^ v_cnt[5];

    assign unused_cnt_bits = ^{h_cnt[9], h_cnt[4:0], v_cnt[9], v_cnt[4:0]};

    // Channel gi: 0 = blue, 1 = green, 2 = red; bar index bit gi drives the same channel.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [3:0] base;
            logic [3:0] chan;

            assign base = expand_2to4(ctrl_active[CTRL_COL_LSB + 2*gi +: 2]);

            always_comb begin
                chan = 4'h0;
                case (pat)
                    PAT_SOLID: chan = base;
                    PAT_VBAR:  chan = h_idx[gi] ? 4'hF : 4'h0;
                    PAT_HBAR:  chan = v_idx[gi] ? 4'hF : 4'h0;
                    PAT_CHECK: chan = checker_on ? base : 4'h0;
                endcase
            end

            assign raw_colour[4*gi +: 4] = chan;
        end
    endgenerate

    // Invert is applied first so that a disabled output stays black even when inverted.
    assign colour = ctrl_active[CTRL_EN] ? (raw_colour ^ {12{ctrl_active[CTRL_INV]}}) : 12'h000;

endmodule

// File: rtl/em_video_timing_gen.sv
// VGA timing and test-pattern generator advancing one pixel per pix_ce; the control
// word is shadowed at the end of each frame so software writes never tear a frame.
module em_video_timing_gen
    import em_video_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pix_ce,
    input  logic [9:0] ctrl_in,
    output logic       vga_hs_n,
    output logic       vga_vs_n,
    output logic       vga_de,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       frame_start,
    output logic [9:0] ctrl_active
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]  h_cnt_reg;
    logic [9:0]  h_cnt_next;
    logic [9:0]  v_cnt_reg;
    logic [9:0]  v_cnt_next;
    logic [9:0]  ctrl_active_reg;
    logic        h_wrap;
    logic        v_wrap;
    logic        frame_end;
    logic        de_next;
    logic        hs_n_next;
    logic        vs_n_next;
    logic [11:0] pat_colour;
    logic [11:0] rgb_next;

    logic        hs_n_reg;
    logic        vs_n_reg;
    logic        de_reg;
    logic [11:0] rgb_reg;
    logic        frame_start_reg;

    em_video_pattern u_pattern (
        .h_cnt       (h_cnt_reg),
        .v_cnt       (v_cnt_reg),
        .ctrl_active (ctrl_active_reg),
        .colour      (pat_colour)
    );

    // Everything decodes from the pre-increment counters, giving one pix_ce of latency.
    always_comb begin
        h_wrap     = (h_cnt_reg == H_LAST);
        v_wrap     = (v_cnt_reg == V_LAST);
        frame_end  = h_wrap && v_wrap;
        h_cnt_next = h_wrap ? 10'd0 : h_cnt_reg + 10'd1;
        v_cnt_next = v_cnt_reg;
        if (h_wrap) begin
            v_cnt_next = v_wrap ? 10'd0 : v_cnt_reg + 10'd1;
        end
        de_next   = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
        hs_n_next = !((h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST));
        vs_n_next = !((v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST));
        rgb_next  = de_next ? pat_colour : 12'h000;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            ctrl_active_reg <= '0;
            hs_n_reg        <= 1'b1;
            vs_n_reg        <= 1'b1;
            de_reg          <= 1'b0;
            rgb_reg         <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            // frame_start is a single-clk strobe, so it clears even when pix_ce is low.
            frame_start_reg <= 1'b0;
            if (pix_ce) begin
                h_cnt_reg       <= h_cnt_next;
                v_cnt_reg       <= v_cnt_next;
                hs_n_reg        <= hs_n_next;
                vs_n_reg        <= vs_n_next;
                de_reg          <= de_next;
                rgb_reg         <= rgb_next;
                frame_start_reg <= (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
                if (frame_end) begin
                    ctrl_active_reg <= ctrl_in;
                end
            end
        end
    end

    assign vga_hs_n    = hs_n_reg;
    assign vga_vs_n    = vs_n_reg;
    assign vga_de      = de_reg;
    assign vga_r       = rgb_reg[11:8];
    assign vga_g       = rgb_reg[7:4];
    assign vga_b       = rgb_reg[3:0];
    assign frame_start = frame_start_reg;
    assign ctrl_active = ctrl_active_reg;

endmodule

// File: tb/tb_em_video_timing_gen.sv
// Directed bench for em_video_timing_gen on a reduced 76x72 raster so that many frames
// fit in a short run; expected values are hand-computed for that geometry.
module tb_em_video_timing_gen;

    localparam int H_ACT = 68;
    localparam int H_FP  = 2;
    localparam int H_SYN = 4;
    localparam int H_BP  = 2;
    localparam int V_ACT = 66;
    localparam int V_FP  = 2;
    localparam int V_SYN = 2;
    localparam int V_BP  = 2;
    localparam int H_T     = 76;
    localparam int V_T     = 72;
    localparam int FRAME   = H_T * V_T;
    localparam int ACT_PIX = H_ACT * V_ACT;
    localparam int N_MAIN  = 8 * FRAME + 20 * H_T + 31;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pix_ce;
    logic [9:0] ctrl_in;
    logic       vga_hs_n;
    logic       vga_vs_n;
    logic       vga_de;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       frame_start;
    logic [9:0] ctrl_active;
    logic [11:0] rgb;

    assign rgb = {vga_r, vga_g, vga_b};

    always #5 clk = ~clk;

    em_video_timing_gen #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYN), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYN), .V_BP (V_BP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_ce      (pix_ce),
        .ctrl_in     (ctrl_in),
        .vga_hs_n    (vga_hs_n),
        .vga_vs_n    (vga_vs_n),
        .vga_de      (vga_de),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start),
        .ctrl_active (ctrl_active)
    );

    typedef struct packed { int f; int h; int v; int hs; int vs; int de; int rgb; } pix_vec_t;
    typedef struct packed { int f; int h; int v; int val; } ctrl_ev_t;

    // {frame, h, v, hs_n, vs_n, de, rgb} for the pixel output at that position.
    pix_vec_t pix_tab [38] = '{
        '{0, 0, 0, 1,1,1,'h000}, '{0,69, 3, 1,1,0,'h000}, '{0,70, 3, 0,1,0,'h000},
        '{0,73, 3, 0,1,0,'h000}, '{0,74, 3, 1,1,0,'h000}, '{0,75,71, 1,1,0,'h000},
        '{0,10,67, 1,1,0,'h000}, '{0,10,68, 1,0,0,'h000}, '{0,10,69, 1,0,0,'h000},
        '{0,10,70, 1,1,0,'h000}, '{0,72,68, 0,0,0,'h000},
        '{1, 0, 0, 1,1,1,'hFFF}, '{1,67,65, 1,1,1,'hFFF}, '{1,68,65, 1,1,0,'h000},
        '{1, 5,66, 1,1,0,'h000},
        '{2, 0, 5, 1,1,1,'h000}, '{2,63, 5, 1,1,1,'h000}, '{2,64, 5, 1,1,1,'h00F},
        '{2,67, 5, 1,1,1,'h00F},
        '{3,10,10, 1,1,1,'h000}, '{3, 0,64, 1,1,1,'h00F}, '{3,67,65, 1,1,1,'h00F},
        '{3,63,63, 1,1,1,'h000},
        '{4, 0, 0, 1,1,1,'h000}, '{4,32, 0, 1,1,1,'hF0A}, '{4,32,32, 1,1,1,'h000},
        '{4, 0,32, 1,1,1,'hF0A}, '{4,31,31, 1,1,1,'h000},
        '{5,10,10, 1,1,1,'hF00}, '{5,10,50, 1,1,1,'hF00}, '{5,67,65, 1,1,1,'hF00},
        '{6, 0, 0, 1,1,1,'h00F}, '{6,40,40, 1,1,1,'h00F},
        '{7, 5, 5, 1,1,1,'h0FF}, '{7,70, 5, 0,1,0,'h000},
        '{8, 0, 0, 1,1,1,'h000}, '{8,70, 1, 0,1,0,'h000}, '{8,30,20, 1,1,1,'h000}
    };

    // ctrl_in is written just after the listed pixel has been output.
    ctrl_ev_t ctrl_wr [7] = '{
        '{1,20,30,'h003}, '{2,30,30,'h005}, '{3,40,40,'h197}, '{4,50,40,'h181},
        '{5, 0,20,'h019}, '{6, 0,30,'h381}, '{7, 0,30,'h3F8}
    };

    ctrl_ev_t ctrl_chk [4] = '{
        '{0,74,71,'h000}, '{0,75,71,'h1F9}, '{5,74,71,'h181}, '{5,75,71,'h019}
    };

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input logic ce);
        @(negedge clk);
        pix_ce = ce;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f, h, v;
        int de_cnt, hs_low, vs_low, blank_nz, fs_cnt;
        int black_nz, white_cnt, fs_bad;
        int hold_bad, fsc_bad, fs_seen, n_fall;
        int fall_t [3];
        logic [14:0] prev_out;
        logic [14:0] cur_out;

        de_cnt = 0; hs_low = 0; vs_low = 0; blank_nz = 0; fs_cnt = 0;
        black_nz = 0; white_cnt = 0; fs_bad = 0;
        hold_bad = 0; fsc_bad = 0; fs_seen = 0; n_fall = 0;
        fall_t = '{0, 0, 0};

        reset_n = 1'b0;
        pix_ce  = 1'b1;
        ctrl_in = 10'h1F9;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hs_n", 32'(vga_hs_n), 1);
        check_val("rst_vs_n", 32'(vga_vs_n), 1);
        check_val("rst_de", 32'(vga_de), 0);
        check_val("rst_rgb", 32'(rgb), 'h000);
        check_val("rst_fs", 32'(frame_start), 0);
        check_val("rst_ctrl", 32'(ctrl_active), 0);
        @(negedge clk);
        reset_n = 1'b1;
        pix_ce  = 1'b0;

        for (int n = 0; n < N_MAIN; n++) begin
            tick(1'b1);
            f = n / FRAME;
            h = (n % FRAME) % H_T;
            v = (n % FRAME) / H_T;
            if (vga_de) de_cnt++;
            if (!vga_hs_n) hs_low++;
            if (!vga_vs_n) vs_low++;
            if (!vga_de && rgb != 12'h000) blank_nz++;
            if (f == 0 && rgb != 12'h000) black_nz++;
            if (f == 1 && vga_de && rgb == 12'hFFF) white_cnt++;
            if (frame_start) begin
                fs_cnt++;
                if (h != 0 || v != 0) fs_bad++;
            end
            for (int k = 0; k < 38; k++) begin
                if (pix_tab[k].f == f && pix_tab[k].h == h && pix_tab[k].v == v) begin
                    check_val($sformatf("pix%0d_hs_n", k), 32'(vga_hs_n), pix_tab[k].hs);
                    check_val($sformatf("pix%0d_vs_n", k), 32'(vga_vs_n), pix_tab[k].vs);
                    check_val($sformatf("pix%0d_de", k), 32'(vga_de), pix_tab[k].de);
                    check_val($sformatf("pix%0d_rgb", k), 32'(rgb), pix_tab[k].rgb);
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (ctrl_chk[k].f == f && ctrl_chk[k].h == h && ctrl_chk[k].v == v)
                    check_val($sformatf("ctrl%0d", k), 32'(ctrl_active), ctrl_chk[k].val);
            end
            if (h == H_T - 1 && v == V_T - 1) begin
                check_val($sformatf("f%0d_de_count", f), de_cnt, ACT_PIX);
                check_val($sformatf("f%0d_hs_low", f), hs_low, H_SYN * V_T);
                check_val($sformatf("f%0d_vs_low", f), vs_low, V_SYN * H_T);
                check_val($sformatf("f%0d_blank_rgb", f), blank_nz, 0);
                check_val($sformatf("f%0d_fs_count", f), fs_cnt, 1);
                de_cnt = 0; hs_low = 0; vs_low = 0; blank_nz = 0; fs_cnt = 0;
            end
            for (int k = 0; k < 7; k++) begin
                if (ctrl_wr[k].f == f && ctrl_wr[k].h == h && ctrl_wr[k].v == v)
                    ctrl_in = 10'(ctrl_wr[k].val);
            end
        end
        check_val("f0_black", black_nz, 0);
        check_val("f1_white", white_cnt, ACT_PIX);
        check_val("fs_position", fs_bad, 0);

        // Asynchronous reset while showing pixel (30,20) of an active line.
        #2;
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_hs_n", 32'(vga_hs_n), 1);
        check_val("mid_rst_vs_n", 32'(vga_vs_n), 1);
        check_val("mid_rst_de", 32'(vga_de), 0);
        check_val("mid_rst_rgb", 32'(rgb), 'h000);
        check_val("mid_rst_fs", 32'(frame_start), 0);
        check_val("mid_rst_ctrl", 32'(ctrl_active), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        pix_ce  = 1'b0;
        reset_n = 1'b1;

        // pix_ce on every other clk for three lines.
        prev_out = {vga_hs_n, vga_vs_n, vga_de, rgb};
        for (int cc = 0; cc < 6 * H_T; cc++) begin
            tick(cc % 2 == 0);
            cur_out = {vga_hs_n, vga_vs_n, vga_de, rgb};
            if (cc == 0) begin
                check_val("restart_fs", 32'(frame_start), 1);
                check_val("restart_de", 32'(vga_de), 1);
                check_val("restart_ctrl", 32'(ctrl_active), 0);
            end
            if (cc == 1) check_val("fs_width", 32'(frame_start), 0);
            if (cc % 2 == 1) begin
                if (cur_out != prev_out) hold_bad++;
                if (frame_start) fsc_bad++;
            end else if (frame_start) begin
                fs_seen++;
            end
            if (prev_out[14] && !vga_hs_n) begin
                if (n_fall < 3) fall_t[n_fall] = cc;
                n_fall++;
            end
            prev_out = cur_out;
        end
        check_val("ce_low_hold", hold_bad, 0);
        check_val("ce_low_fs", fsc_bad, 0);
        check_val("half_rate_fs_count", fs_seen, 1);
        check_val("hs_fall_count", n_fall, 3);
        check_val("hs_first_fall", fall_t[0], 140);
        check_val("line_period_1", fall_t[1] - fall_t[0], 2 * H_T);
        check_val("line_period_2", fall_t[2] - fall_t[1], 2 * H_T);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
